switch_mcu_lsu: RTL
===================

Name: switch_mcu_lsu

Overview:
Load/store unit directly downstream of the execute stage of the switch MCU core. It takes one decoded load/store request (op flags, effective address, store data, rd) per access. It runs a single AHB-Lite data-bus transfer and returns the aligned, sign- or zero-extended load result with a register write-back strobe. The core is stalled via out_busy until the access completes.

Parameters:
TIMEOUT_CYCLES, 16, maximum wait-state cycles (in_hready=0) tolerated per transfer before abort (used only with the optional feature)
RESET_ADDR, 32'h0000_0000, value of out_haddr in reset and idle

Ports:
in_clk  input  1  core clock
in_rst  input  1  asynchronous reset, active-low
in_req  input  1  one-cycle request strobe from execute stage
in_lb/in_lh/in_lw/in_lbu/in_lhu/in_sb/in_sh/in_sw  input  1 each  one-hot op flags, valid with in_req
in_addr  input  32  effective address (rs1 + imm)
in_wdata  input  32  store data (rs2)
in_rd  input  5  load destination register
out_busy  output  1  high while state != IDLE; core holds pipeline
out_done  output  1  one-cycle completion pulse
out_err  output  1  valid with out_done: misaligned, illegal op, bus error or timeout
out_rd_we  output  1  one-cycle register write strobe (successful load, rd != 0)
out_rd  output  5  write-back register index
out_rdata  output  32  extended load result, held until next out_done
in_hready  input  1  AHB transfer ready
in_hresp  input  1  AHB response, 1 = ERROR
in_hrdata  input  32  AHB read data
out_haddr  output  32  AHB address
out_hwrite  output  1  1 = write
out_hsize  output  3  000 byte, 001 half, 010 word
out_htrans  output  2  00 IDLE, 10 NONSEQ
out_hwdata  output  32  AHB write data

Behaviour:
- Reset (in_rst=0, async): state IDLE, all outputs 0, out_haddr=RESET_ADDR, out_htrans=00. Asserting reset mid-transfer drops the transfer immediately, with no done pulse.
- FSM states: IDLE, ADDR, DATA.
- IDLE: in_req is sampled at edge E0.
  - Legal and aligned: latch op/addr/wdata/rd and go to ADDR.
  - Otherwise (zero or multiple flags; lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0): stay IDLE, no bus activity. Pulse out_done=1, out_err=1 in the cycle after E0; out_rd_we=0.
- ADDR: drive out_htrans=10, out_haddr=latched addr, out_hwrite, out_hsize.
  - in_hready=1 at an edge: go to DATA, out_htrans returns to 00.
  - in_hready=0: hold all address-phase outputs.
- DATA: out_hwdata is driven from latched wdata, replicated per size: sb {4{wdata[7:0]}}, sh {2{wdata[15:0]}}, sw wdata. It stays stable until completion.
  - Edge with in_hready=1 completes the access and the next state is IDLE.
  - In the cycle after that edge: out_done=1 and out_err=in_hresp.
- Load extraction at completion:
  - lb/lbu: byte in_hrdata[8*a+7:8*a] with a=addr[1:0], sign-/zero-extended.
  - lh/lhu: half in_hrdata[16*h+15:16*h] with h=addr[1], sign-/zero-extended.
  - lw: in_hrdata.
- Write-back: out_rd_we=1 only for a load with no error and rd!=0. out_rdata is updated only on a successful load.
- Zero-wait latency: req at E0, address phase after E0, data phase after E1, done visible after E2 (3 cycles).
- in_req while out_busy=1 is ignored (no queueing, no error).
- out_busy drops in the same cycle out_done pulses, so a new in_req may be sampled at the following edge.

Optional Feature:
SWITCH_MCU_LSU_TIMEOUT_EN:
- Defined: a wait counter clears on entry to ADDR and increments on every ADDR/DATA cycle with in_hready=0.
- When the counter reaches TIMEOUT_CYCLES, the block forces IDLE, out_htrans=00, and pulses out_done=1, out_err=1 with out_rd_we=0.
- Undefined: no counter, and the block waits for in_hready indefinitely.

Test Plan:
- Zero-wait load: lw, addr=0x100, hrdata=0xDEADBEEF, rd=5 -> htrans=10 for 1 cycle; out_done, out_rd_we, out_rdata=0xDEADBEEF, out_rd=5 three cycles after req.
- Byte loads: hrdata=0x80FF7F01 at addr 0x203. lb gives out_rdata=0xFFFFFF80; lbu gives 0x00000080; lh at 0x202 gives 0xFFFF80FF.
- Store lanes: sh, addr=0x12, wdata=0x1234ABCD -> hsize=001, hwdata=0xABCDABCD, hwrite=1, out_rd_we=0, out_err=0.
- Wait states/error: lw with hready low for 3 ADDR + 2 DATA cycles -> outputs held, done 8 cycles after req; same run with hresp=1 at completion -> out_err=1, out_rd_we=0, out_rdata unchanged.
- Misaligned/illegal: sw at 0x101, or req with lb+sw both set -> no htrans activity, out_done=out_err=1 the next cycle; rd=0 load -> out_rd_we=0.
- Reset/timeout: in_rst low during DATA -> htrans=00, busy=0, no done. With SWITCH_MCU_LSU_TIMEOUT_EN and hready stuck low -> done+err after 16 wait cycles.

Source files
------------

// File: rtl/switch_mcu_lsu_if.sv
// AHB-Lite data-bus bundle between the switch MCU load/store unit (master)
// and the data-side fabric (slave).
interface switch_mcu_lsu_if;
  logic        in_hready;
  logic        in_hresp;
  logic [31:0] in_hrdata;
  logic [31:0] out_haddr;
  logic        out_hwrite;
  logic [2:0]  out_hsize;
  logic [1:0]  out_htrans;
  logic [31:0] out_hwdata;

  modport master (
    input  in_hready, in_hresp, in_hrdata,
    output out_haddr, out_hwrite, out_hsize, out_htrans, out_hwdata
  );

  modport slave (
    output in_hready, in_hresp, in_hrdata,
    input  out_haddr, out_hwrite, out_hsize, out_htrans, out_hwdata
  );
endinterface

// File: rtl/switch_mcu_lsu.sv
// Switch MCU load/store unit: one AHB-Lite transfer per decoded load/store.
// Optional wait-state timeout: define SWITCH_MCU_LSU_TIMEOUT_EN.
module switch_mcu_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] RESET_ADDR     = 32'h0000_0000
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_req,
  input  logic                  in_lb,
  input  logic                  in_lh,
  input  logic                  in_lw,
  input  logic                  in_lbu,
  input  logic                  in_lhu,
  input  logic                  in_sb,
  input  logic                  in_sh,
  input  logic                  in_sw,
  input  logic [31:0]           in_addr,
  input  logic [31:0]           in_wdata,
  input  logic [4:0]            in_rd,
  output logic                  out_busy,
  output logic                  out_done,
  output logic                  out_err,
  output logic                  out_rd_we,
  output logic [4:0]            out_rd,
  output logic [31:0]           out_rdata,
  output logic [1:0]            out_dbg_state,
  switch_mcu_lsu_if.master      ahb
);

  // Handshake: in_req is a one-cycle strobe taken only while out_busy is low;
  // an AHB phase (address or data) advances on any edge with in_hready=1.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_is_load;
  logic        r_is_signed;
  logic [1:0]  r_size;
  logic [1:0]  r_addr_lo;
  logic [4:0]  r_rd_lat;
  logic [31:0] r_wdata;
  logic        r_done;
  logic        r_err;
  logic        r_rd_we;
  logic [4:0]  r_rd;
  logic [31:0] r_rdata;
  logic [31:0] r_haddr;
  logic        r_hwrite;
  logic [2:0]  r_hsize;
  logic [1:0]  r_htrans;
  logic [31:0] r_hwdata;

  logic [7:0]  w_ops;
  logic        w_is_store;
  logic [1:0]  w_size;
  logic        w_misalign;
  logic        w_legal;
  logic [31:0] w_wdata_rep;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val;
  logic        w_timeout;

  assign w_ops      = {in_lb, in_lh, in_lw, in_lbu, in_lhu, in_sb, in_sh, in_sw};
  assign w_is_store = in_sb | in_sh | in_sw;

  always_comb begin
    w_size = 2'd2;
    if (in_lb | in_lbu | in_sb)      w_size = 2'd0;
    else if (in_lh | in_lhu | in_sh) w_size = 2'd1;
  end

  assign w_misalign = ((w_size == 2'd1) && in_addr[0]) ||
                      ((w_size == 2'd2) && (in_addr[1:0] != 2'b00));
  assign w_legal    = $onehot(w_ops) && !w_misalign;

  always_comb begin
    case (w_size)
      2'd0:    w_wdata_rep = {4{in_wdata[7:0]}};
      2'd1:    w_wdata_rep = {2{in_wdata[15:0]}};
      default: w_wdata_rep = in_wdata;
    endcase
  end

  // Lane select and extension of the returned read data.
  always_comb begin
    case (r_addr_lo)
      2'd1:    w_byte = ahb.in_hrdata[15:8];
      2'd2:    w_byte = ahb.in_hrdata[23:16];
      2'd3:    w_byte = ahb.in_hrdata[31:24];
      default: w_byte = ahb.in_hrdata[7:0];
    endcase
    w_half = r_addr_lo[1] ? ahb.in_hrdata[31:16] : ahb.in_hrdata[15:0];
    case (r_size)
      2'd0:    w_load_val = {{24{r_is_signed & w_byte[7]}}, w_byte};
      2'd1:    w_load_val = {{16{r_is_signed & w_half[15]}}, w_half};
      default: w_load_val = ahb.in_hrdata;
    endcase
  end

`ifdef SWITCH_MCU_LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_wait_cnt;

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst)                 r_wait_cnt <= '0;
    else if (r_state == S_IDLE)  r_wait_cnt <= '0;
    else if (!ahb.in_hready)     r_wait_cnt <= r_wait_cnt + 1'b1;
  end

  assign w_timeout = (r_state != S_IDLE) && !ahb.in_hready &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // The limit only has meaning in the timeout build.
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_state     <= S_IDLE;
      r_is_load   <= 1'b0;
      r_is_signed <= 1'b0;
      r_size      <= 2'd0;
      r_addr_lo   <= 2'd0;
      r_rd_lat    <= 5'd0;
      r_wdata     <= 32'd0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rd_we     <= 1'b0;
      r_rd        <= 5'd0;
      r_rdata     <= 32'd0;
      r_haddr     <= RESET_ADDR;
      r_hwrite    <= 1'b0;
      r_hsize     <= 3'd0;
      r_htrans    <= 2'b00;
      r_hwdata    <= 32'd0;
    end else begin
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rd_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_req) begin
            if (w_legal) begin
              r_state     <= S_ADDR;
              r_is_load   <= !w_is_store;
              r_is_signed <= in_lb | in_lh;
              r_size      <= w_size;
              r_addr_lo   <= in_addr[1:0];
              r_rd_lat    <= in_rd;
              r_wdata     <= w_wdata_rep;
              r_haddr     <= in_addr;
              r_hwrite    <= w_is_store;
              r_hsize     <= {1'b0, w_size};
              r_htrans    <= 2'b10;
            end else begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end
          end
        end
        S_ADDR, S_DATA: begin
          if (w_timeout || (r_state == S_DATA && ahb.in_hready)) begin
            r_state  <= S_IDLE;
            r_haddr  <= RESET_ADDR;
            r_hwrite <= 1'b0;
            r_hsize  <= 3'd0;
            r_htrans <= 2'b00;
            r_hwdata <= 32'd0;
            r_done   <= 1'b1;
            r_err    <= w_timeout | ahb.in_hresp;
            if (!w_timeout && !ahb.in_hresp && r_is_load) begin
              r_rdata <= w_load_val;
              r_rd    <= r_rd_lat;
              r_rd_we <= (r_rd_lat != 5'd0);
            end
          end else if (r_state == S_ADDR && ahb.in_hready) begin
            r_state  <= S_DATA;
            r_htrans <= 2'b00;
            r_hwdata <= r_wdata;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_busy       = (r_state != S_IDLE);
  assign out_done       = r_done;
  assign out_err        = r_err;
  assign out_rd_we      = r_rd_we;
  assign out_rd         = r_rd;
  assign out_rdata      = r_rdata;
  assign out_dbg_state  = r_state;
  assign ahb.out_haddr  = r_haddr;
  assign ahb.out_hwrite = r_hwrite;
  assign ahb.out_hsize  = r_hsize;
  assign ahb.out_htrans = r_htrans;
  assign ahb.out_hwdata = r_hwdata;

endmodule
